// File: rtl/cpu_pkg.sv
// Shared RV32I encoding constants and types used by the program loader and its encoder.
package cpu_pkg;

  localparam logic [6:0]  OPCODE_I_TYPE = 7'b0010011;
  localparam logic [6:0]  OPCODE_R_TYPE = 7'b0110011;
  localparam logic [6:0]  OPCODE_B_TYPE = 7'b1100011;
  localparam logic [2:0]  FUNCT3_ADD    = 3'b000;
  localparam logic [2:0]  FUNCT3_BNE    = 3'b001;
  localparam logic [6:0]  FUNCT7_ADD    = 7'b0000000;
  localparam logic [6:0]  FUNCT7_SUB    = 7'b0100000;
  localparam logic [31:0] NOP_WORD      = 32'h0000_0013;

  typedef enum logic [1:0] {ENC_ADDI, ENC_ADD, ENC_SUB, ENC_BNE} enc_op_t;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FILL, S_DONE} load_state_t;

endpackage

// File: rtl/fib_prog_loader_if.sv
// Instruction-memory write port: the loader drives we/addr/wdata, imem answers with ready.
interface fib_prog_loader_if #(
  parameter int ADDR_W = 32
);
  logic              imem_we;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (output imem_we, output imem_addr, output imem_wdata, input imem_ready);
  modport slave  (input imem_we, input imem_addr, input imem_wdata, output imem_ready);
endinterface

// File: rtl/instr_encoder.sv
// Combinational RV32I field-to-word encoder for addi, add, sub and bne.
module instr_encoder
  import cpu_pkg::*;
(
  input  enc_op_t     op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [12:0] imm,
  output logic [31:0] word
);

  // Branch offsets are always even, so imm[0] has no slot in the B format.
  logic unused_imm0;
  assign unused_imm0 = imm[0];

  always_comb begin
    word = NOP_WORD;
    case (op)
      ENC_ADDI: word = {imm[11:0], rs1, FUNCT3_ADD, rd, OPCODE_I_TYPE};
      ENC_ADD:  word = {FUNCT7_ADD, rs2, rs1, FUNCT3_ADD, rd, OPCODE_R_TYPE};
      ENC_SUB:  word = {FUNCT7_SUB, rs2, rs1, FUNCT3_ADD, rd, OPCODE_R_TYPE};
      ENC_BNE:  word = {imm[12], imm[10:5], rs2, rs1, FUNCT3_BNE, imm[4:1], imm[11], OPCODE_B_TYPE};
      default:  word = NOP_WORD;
    endcase
  end

endmodule

// File: rtl/fib_prog_loader.sv
// Writes the Fibonacci program plus NOP padding into imem while holding the CPU in reset.
//  state  | meaning
//  S_IDLE | waiting for start
//  S_LOAD | writing program words idx 0..7
//  S_FILL | writing NOP padding idx 8..IMEM_DEPTH-1
//  S_DONE | one-cycle done/err pulse, releases cpu_hold on success
module fib_prog_loader
  import cpu_pkg::*;
#(
  parameter int IMEM_DEPTH = 16,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [10:0]       n_iter,
  fib_prog_loader_if.master imem,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_hold
);

  localparam int IDX_W    = $clog2(IMEM_DEPTH);
  localparam bit HAS_FILL = (IMEM_DEPTH > 8);

  if (IMEM_DEPTH < 8) begin : g_depth_check
    $error("fib_prog_loader: IMEM_DEPTH must be >= 8");
  end

  load_state_t       state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [10:0]       n_lat;
  logic              xfer;
  logic              emit;

  enc_op_t           f_op;
  logic [4:0]        f_rd, f_rs1, f_rs2;
  logic [12:0]       f_imm;
  logic [31:0]       enc_word;

  assign xfer = imem.imem_we && imem.imem_ready;
  assign emit = (state_d == S_LOAD) || (state_d == S_FILL);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = (n_iter != 11'd0) ? S_LOAD : S_DONE;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(7)) state_d = HAS_FILL ? S_FILL : S_DONE;
        end
      end
      S_FILL: begin
        if (xfer) begin
          if (idx_q == IDX_W'(IMEM_DEPTH - 1)) state_d = S_DONE;
          else                                 idx_d   = idx_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Fields are looked up for the next index so the output registers load the word in step with idx.
  always_comb begin
    f_op  = ENC_ADDI;
    f_rd  = 5'd0;
    f_rs1 = 5'd0;
    f_rs2 = 5'd0;
    f_imm = 13'd0;
    case (idx_d[2:0])
      3'd0: begin f_op = ENC_ADDI; f_rd = 5'd1; f_rs1 = 5'd0; f_imm = 13'd0; end
      3'd1: begin f_op = ENC_ADDI; f_rd = 5'd2; f_rs1 = 5'd0; f_imm = 13'd1; end
      3'd2: begin f_op = ENC_ADDI; f_rd = 5'd3; f_rs1 = 5'd0; f_imm = {2'b00, n_lat}; end
      3'd3: begin f_op = ENC_ADD;  f_rd = 5'd4; f_rs1 = 5'd1; f_rs2 = 5'd2; end
      3'd4: begin f_op = ENC_ADD;  f_rd = 5'd1; f_rs1 = 5'd2; f_rs2 = 5'd0; end
      3'd5: begin f_op = ENC_ADD;  f_rd = 5'd2; f_rs1 = 5'd4; f_rs2 = 5'd0; end
      3'd6: begin f_op = ENC_ADDI; f_rd = 5'd3; f_rs1 = 5'd3; f_imm = 13'h1FFF; end
      3'd7: begin f_op = ENC_BNE;  f_rs1 = 5'd3; f_rs2 = 5'd0; f_imm = 13'h1FF0; end
      default: f_op = ENC_ADDI;
    endcase
  end

  instr_encoder u_encoder (
    .op   (f_op),
    .rd   (f_rd),
    .rs1  (f_rs1),
    .rs2  (f_rs2),
    .imm  (f_imm),
    .word (enc_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      n_lat           <= '0;
      imem.imem_we    <= 1'b0;
      imem.imem_addr  <= '0;
      imem.imem_wdata <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err             <= 1'b0;
      cpu_hold        <= 1'b1;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      imem.imem_we    <= emit;
      imem.imem_addr  <= emit ? ADDR_W'({idx_d, 2'b00}) : '0;
      imem.imem_wdata <= emit ? ((state_d == S_FILL) ? NOP_WORD : enc_word) : '0;
      busy            <= emit;
      done            <= (state_d == S_DONE);
      err             <= (state_q == S_IDLE) && start && (n_iter == 11'd0);
      if ((state_q == S_IDLE) && start && (n_iter != 11'd0)) begin
        n_lat    <= n_iter;
        cpu_hold <= 1'b1;
      end
      // err is high for exactly the DONE cycle of a rejected request.
      if ((state_q == S_DONE) && !err) cpu_hold <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fib_prog_loader.sv
// Directed bench for fib_prog_loader: scoreboarded imem writes plus encoder spot checks.
module tb_fib_prog_loader;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] n_iter = 11'd0;
  logic        busy, done, err, cpu_hold;

  enc_op_t     e_op = ENC_ADD;
  logic [4:0]  e_rd = 5'd0, e_rs1 = 5'd0, e_rs2 = 5'd0;
  logic [12:0] e_imm = 13'd0;
  logic [31:0] e_word;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] word;
  } wr_t;
  wr_t exp_q[$];

  fib_prog_loader_if #(.ADDR_W(32)) imem_bus ();

  fib_prog_loader #(.IMEM_DEPTH(16), .ADDR_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .n_iter   (n_iter),
    .imem     (imem_bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold)
  );

  instr_encoder enc (
    .op   (e_op),
    .rd   (e_rd),
    .rs1  (e_rs1),
    .rs2  (e_rs2),
    .imm  (e_imm),
    .word (e_word)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  function automatic logic [31:0] model_word(input int i, input logic [10:0] n);
    case (i)
      0: return 32'h0000_0093;
      1: return 32'h0010_0113;
      2: return ({21'd0, n} << 20) | 32'h0000_0193;
      3: return 32'h0020_8233;
      4: return 32'h0001_00B3;
      5: return 32'h0002_0133;
      6: return 32'hFFF1_8193;
      7: return 32'hFE01_98E3;
      default: return 32'h0000_0013;
    endcase
  endfunction

  task automatic push_program(input logic [10:0] n);
    wr_t w;
    for (int i = 0; i < 16; i++) begin
      w.addr = 32'(i * 4);
      w.word = model_word(i, n);
      exp_q.push_back(w);
    end
  endtask

  // Runs one full load; rnd randomises ready, poke re-pulses start mid-load.
  task automatic do_load(input logic [10:0] n, input bit rnd, input bit poke);
    int          cyc = 0;
    int          writes = 0;
    bit          seen_done = 0;
    bit          held = 0;
    logic [31:0] held_a = '0, held_w = '0;
    wr_t         w;
    push_program(n);
    @(negedge clk);
    start  = 1'b1;
    n_iter = n;
    @(negedge clk);
    start  = 1'b0;
    n_iter = ~n;
    check("first_cycle_we", {31'd0, imem_bus.imem_we}, 32'd1);
    check("first_cycle_hold", {31'd0, cpu_hold}, 32'd1);
    check("first_cycle_busy", {31'd0, busy}, 32'd1);
    while (cyc < 200) begin
      if (held) begin
        check("stall_we", {31'd0, imem_bus.imem_we}, 32'd1);
        check("stall_addr", imem_bus.imem_addr, held_a);
        check("stall_wdata", imem_bus.imem_wdata, held_w);
      end
      if (done) begin
        seen_done = 1;
        start = 1'b0;
        break;
      end
      imem_bus.imem_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      start = (poke && (cyc % 5 == 2)) ? 1'b1 : 1'b0;
      held = 0;
      if (imem_bus.imem_we) begin
        if (imem_bus.imem_ready) begin
          writes++;
          if (exp_q.size() == 0) begin
            check("extra_write_addr", imem_bus.imem_addr, 32'hFFFF_FFFF);
          end else begin
            w = exp_q.pop_front();
            check("write_addr", imem_bus.imem_addr, w.addr);
            check("write_word", imem_bus.imem_wdata, w.word);
          end
        end else begin
          held   = 1;
          held_a = imem_bus.imem_addr;
          held_w = imem_bus.imem_wdata;
        end
      end
      @(negedge clk);
      cyc++;
    end
    imem_bus.imem_ready = 1'b1;
    check("done_seen", {31'd0, seen_done}, 32'd1);
    check("write_count", 32'(writes), 32'd16);
    check("done_err", {31'd0, err}, 32'd0);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_we", {31'd0, imem_bus.imem_we}, 32'd0);
    if (!rnd) check("load_cycles", 32'(cyc), 32'd16);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("done_single_pulse", {31'd0, done}, 32'd0);
      check("after_done_we", {31'd0, imem_bus.imem_we}, 32'd0);
    end
    check("hold_released", {31'd0, cpu_hold}, 32'd0);
    exp_q.delete();
  endtask

  initial begin
    imem_bus.imem_ready = 1'b1;

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_we", {31'd0, imem_bus.imem_we}, 32'd0);
    check("rst_addr", imem_bus.imem_addr, 32'd0);
    check("rst_wdata", imem_bus.imem_wdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_hold", {31'd0, cpu_hold}, 32'd1);
    rst = 1'b0;

    // n_iter == 0 rejected: no writes, err with done, hold unchanged
    @(negedge clk);
    start  = 1'b1;
    n_iter = 11'd0;
    @(negedge clk);
    start  = 1'b0;
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_err", {31'd0, err}, 32'd1);
    check("zero_we", {31'd0, imem_bus.imem_we}, 32'd0);
    check("zero_hold", {31'd0, cpu_hold}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("zero_no_write", {31'd0, imem_bus.imem_we}, 32'd0);
      check("zero_done_low", {31'd0, done}, 32'd0);
      check("zero_hold_kept", {31'd0, cpu_hold}, 32'd1);
    end

    // Zero-wait load, n_iter = 10
    do_load(11'd10, 1'b0, 1'b0);

    // Random ready back-pressure
    do_load(11'd3, 1'b1, 1'b0);

    // Max n_iter with start pulses during load
    do_load(11'd2047, 1'b0, 1'b1);

    // Reset mid-load at idx 4, then a fresh load from address 0
    @(negedge clk);
    start  = 1'b1;
    n_iter = 11'd5;
    @(negedge clk);
    start  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (imem_bus.imem_we && imem_bus.imem_addr == 32'h10) break;
      @(negedge clk);
    end
    check("abort_reached_idx4", imem_bus.imem_addr, 32'h10);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_we", {31'd0, imem_bus.imem_we}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hold", {31'd0, cpu_hold}, 32'd1);
    check("abort_addr", imem_bus.imem_addr, 32'd0);
    do_load(11'd6, 1'b0, 1'b0);

    // Encoder unit checks
    e_op = ENC_SUB; e_rd = 5'd5; e_rs1 = 5'd6; e_rs2 = 5'd7; e_imm = 13'd0;
    #1 check("enc_sub", e_word, 32'h4073_02B3);
    e_op = ENC_ADD; e_rd = 5'd0; e_rs1 = 5'd0; e_rs2 = 5'd0;
    #1 check("enc_add_zero", e_word, 32'h0000_0033);
    e_op = ENC_BNE; e_rs1 = 5'd3; e_rs2 = 5'd0; e_imm = 13'h1FF0;
    #1 check("enc_bne", e_word, 32'hFE01_98E3);
    e_op = ENC_ADDI; e_rd = 5'd3; e_rs1 = 5'd3; e_imm = 13'h1FFF;
    #1 check("enc_addi_neg", e_word, 32'hFFF1_8193);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
